// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the fetch/data main-memory arbiter.
package mem_bus_arbiter_pkg;

   localparam int unsigned TimeoutDefault = 64;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBus  = 2'd1,
      StResp = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OwnNone  = 2'b00,
      OwnFetch = 2'b01,
      OwnData  = 2'b10
   } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_bus_arbiter_if
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) ();

   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          bus_err;
   owner_e        owner;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
             bus_err, owner
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
             bus_err, owner
   );

endinterface

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Counts bus cycles of the current transaction and flags the last allowed one.
module bus_watchdog
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT);
   // Expiry fires in the cycle whose increment would make the count TIMEOUT-1.
   localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 2);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = run && (cnt_q == LastCnt);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one main-memory port between fetch refill and data access, one
// transaction at a time, alternating on ties and aborting hung transfers.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input logic               clk,
   input logic               reset,
   mem_bus_arbiter_if.slave  bus
);

   arb_state_e    state_q, state_d;
   owner_e        owner_q, owner_d;
   owner_e        last_q, last_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          err_q, err_d;
   logic          grant_fetch, grant_data;
   logic          expired;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .run     (state_q == StBus),
      .clear   (state_q == StResp),
      .expired (expired)
   );

   // On a tie the side that did not win last time is granted.
   assign grant_fetch = bus.i_req && (!bus.d_req || (last_q == OwnData));
   assign grant_data  = bus.d_req && (!bus.i_req || (last_q == OwnFetch));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.i_req || bus.d_req) state_d = StBus;
         StBus:   if (bus.mem_ack || expired) state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      owner_d     = owner_q;
      last_d      = last_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      err_d       = err_q;
      unique case (state_q)
         StIdle: begin
            if (grant_data) begin
               owner_d     = OwnData;
               last_d      = OwnData;
               mem_we_d    = bus.d_we;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
            end else if (grant_fetch) begin
               owner_d     = OwnFetch;
               last_d      = OwnFetch;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.i_addr;
               mem_wdata_d = '0;
            end
         end
         StBus: begin
            // A real ack beats the watchdog when both land in one cycle.
            if (bus.mem_ack || expired) begin
               err_d = !bus.mem_ack;
               if (owner_q == OwnFetch) i_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
               if (owner_q == OwnData)  d_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
            end
         end
         StResp: begin
            owner_d = OwnNone;
            err_d   = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         owner_q     <= OwnNone;
         last_q      <= OwnFetch;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         last_q      <= last_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      bus.mem_req   = (state_q == StBus);
      bus.i_ack     = (state_q == StResp) && (owner_q == OwnFetch);
      bus.d_ack     = (state_q == StResp) && (owner_q == OwnData);
      bus.bus_err   = (state_q == StResp) && err_q;
      bus.owner     = owner_q;
      bus.mem_we    = mem_we_q;
      bus.mem_addr  = mem_addr_q;
      bus.mem_wdata = mem_wdata_q;
      bus.i_rdata   = i_rdata_q;
      bus.d_rdata   = d_rdata_q;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed checks of the arbiter; dut_a uses a long watchdog, dut_b a short one.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   int n_total = 0;
   int n_bad   = 0;

   mem_bus_arbiter_if #(.AW(32), .DW(32)) bus_a ();
   mem_bus_arbiter_if #(.AW(32), .DW(32)) bus_b ();

   assign bus_a.i_req = i_req;     assign bus_b.i_req = i_req;
   assign bus_a.i_addr = i_addr;   assign bus_b.i_addr = i_addr;
   assign bus_a.d_req = d_req;     assign bus_b.d_req = d_req;
   assign bus_a.d_we = d_we;       assign bus_b.d_we = d_we;
   assign bus_a.d_addr = d_addr;   assign bus_b.d_addr = d_addr;
   assign bus_a.d_wdata = d_wdata; assign bus_b.d_wdata = d_wdata;
   assign bus_a.mem_rdata = mem_rdata; assign bus_b.mem_rdata = mem_rdata;
   assign bus_a.mem_ack = mem_ack; assign bus_b.mem_ack = mem_ack;

   mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(64)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0; d_we = 1'b0;
      tick; tick;
      reset = 1'b1;
   endtask

   int          cnt, addr_bad, n_acks, seen;
   logic [1:0]  acks [4];
   logic [1:0]  exp_acks [4];

   initial begin
      exp_acks[0] = 2'b10; exp_acks[1] = 2'b01; exp_acks[2] = 2'b10; exp_acks[3] = 2'b01;

      // Reset state and single fetch.
      do_reset;
      check_eq("rst_mem_req", bus_a.mem_req, 0);
      check_eq("rst_owner", bus_a.owner, 0);
      check_eq("rst_acks", {bus_a.i_ack, bus_a.d_ack, bus_a.bus_err}, 0);
      check_eq("rst_rdata", bus_a.i_rdata | bus_a.d_rdata, 0);
      i_req = 1'b1; i_addr = 32'h100;
      tick;
      check_eq("f_mem_req", bus_a.mem_req, 1);
      check_eq("f_mem_addr", bus_a.mem_addr, 32'h100);
      check_eq("f_mem_we", bus_a.mem_we, 0);
      check_eq("f_owner", bus_a.owner, 2'b01);
      mem_ack = 1'b1; mem_rdata = 32'h8C22_0004;
      tick;
      check_eq("f_i_ack", bus_a.i_ack, 1);
      check_eq("f_i_rdata", bus_a.i_rdata, 32'h8C22_0004);
      check_eq("f_err", bus_a.bus_err, 0);
      check_eq("f_mem_req_resp", bus_a.mem_req, 0);
      mem_ack = 1'b0; i_req = 1'b0;
      tick;
      check_eq("f_ack_drop", bus_a.i_ack, 0);
      check_eq("f_owner_idle", bus_a.owner, 0);

      // Simultaneous requests from reset: data wins first.
      do_reset;
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
      tick;
      check_eq("s_owner_d", bus_a.owner, 2'b10);
      check_eq("s_mem_we", bus_a.mem_we, 1);
      check_eq("s_mem_wdata", bus_a.mem_wdata, 32'hDEAD_BEEF);
      check_eq("s_mem_addr", bus_a.mem_addr, 32'h40);
      mem_ack = 1'b1; mem_rdata = 32'h11;
      tick;
      check_eq("s_acks_d", {bus_a.i_ack, bus_a.d_ack}, 2'b01);
      d_req = 1'b0; mem_ack = 1'b0;
      tick;
      check_eq("s_idle_owner", bus_a.owner, 0);
      tick;
      check_eq("s_owner_i", bus_a.owner, 2'b01);
      check_eq("s_mem_addr_i", bus_a.mem_addr, 32'h200);
      check_eq("s_mem_we_i", bus_a.mem_we, 0);
      mem_ack = 1'b1; mem_rdata = 32'h22;
      tick;
      check_eq("s_acks_i", {bus_a.i_ack, bus_a.d_ack}, 2'b10);
      check_eq("s_i_rdata", bus_a.i_rdata, 32'h22);
      check_eq("s_d_rdata_hold", bus_a.d_rdata, 32'h11);
      d_req = 1'b1; d_we = 1'b0;
      n_acks = 0;
      for (int k = 0; k < 12; k++) begin
         tick;
         if (bus_a.i_ack || bus_a.d_ack) begin
            if (n_acks < 4) acks[n_acks] = {bus_a.d_ack, bus_a.i_ack};
            n_acks++;
         end
      end
      check_eq("alt_count", n_acks, 4);
      for (int k = 0; k < 4; k++) check_eq($sformatf("alt_%0d", k), acks[k], exp_acks[k]);

      // Slow memory on dut_a.
      do_reset;
      i_req = 1'b1; i_addr = 32'h300;
      tick;
      cnt = 0; addr_bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus_a.mem_req) cnt++;
         if (bus_a.mem_addr != 32'h300) addr_bad++;
         if (k == 9) begin mem_ack = 1'b1; mem_rdata = 32'h33; end
         tick;
      end
      check_eq("slow_req_cycles", cnt, 10);
      check_eq("slow_addr_stable", addr_bad, 0);
      check_eq("slow_ack", bus_a.i_ack, 1);
      check_eq("slow_err", bus_a.bus_err, 0);
      check_eq("slow_rdata", bus_a.i_rdata, 32'h33);
      mem_ack = 1'b0; i_req = 1'b0;
      tick;
      check_eq("slow_single_pulse", bus_a.i_ack, 0);

      // Timeout on dut_b (TIMEOUT=8), preceded by a good read to load d_rdata.
      do_reset;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; mem_ack = 1'b1; mem_rdata = 32'h55;
      tick;
      tick;
      check_eq("to_pre_ack", bus_b.d_ack, 1);
      check_eq("to_pre_rdata", bus_b.d_rdata, 32'h55);
      mem_ack = 1'b0;
      tick;
      tick;
      cnt = 0; seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus_b.d_ack) begin seen = 1; break; end
         if (bus_b.mem_req) cnt++;
         tick;
      end
      check_eq("to_ack_seen", seen, 1);
      check_eq("to_req_cycles", cnt, 7);
      check_eq("to_bus_err", bus_b.bus_err, 1);
      check_eq("to_rdata_zero", bus_b.d_rdata, 0);
      d_req = 1'b0;
      tick;
      check_eq("to_err_clear", {bus_b.bus_err, bus_b.d_ack}, 0);
      i_req = 1'b1; i_addr = 32'h400;
      tick;
      mem_ack = 1'b1; mem_rdata = 32'h44;
      tick;
      check_eq("to_next_ack", bus_b.i_ack, 1);
      check_eq("to_next_err", bus_b.bus_err, 0);
      check_eq("to_next_rdata", bus_b.i_rdata, 32'h44);
      mem_ack = 1'b0; i_req = 1'b0;

      // mem_ack in the very cycle the watchdog expires (dut_b).
      do_reset;
      i_req = 1'b1; i_addr = 32'h500;
      tick;
      for (int k = 0; k < 6; k++) tick;
      check_eq("edge_req_last", bus_b.mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'h77;
      tick;
      check_eq("edge_ack", bus_b.i_ack, 1);
      check_eq("edge_err", bus_b.bus_err, 0);
      check_eq("edge_rdata", bus_b.i_rdata, 32'h77);

      // Stray mem_ack while idle (dut_a).
      do_reset;
      mem_ack = 1'b1;
      n_acks = 0; cnt = 0;
      for (int k = 0; k < 3; k++) begin
         tick;
         if (bus_a.i_ack || bus_a.d_ack) n_acks++;
         if (bus_a.mem_req || bus_a.owner != 0) cnt++;
      end
      check_eq("stray_no_ack", n_acks, 0);
      check_eq("stray_idle", cnt, 0);
      mem_ack = 1'b0;

      // Reset mid-transaction, then a clean fetch.
      i_req = 1'b1; i_addr = 32'h600;
      tick;
      check_eq("mid_req", bus_a.mem_req, 1);
      reset = 1'b0;
      tick;
      check_eq("mid_rst_req", bus_a.mem_req, 0);
      check_eq("mid_rst_owner", bus_a.owner, 0);
      check_eq("mid_rst_ack", bus_a.i_ack, 0);
      reset = 1'b1;
      tick;
      check_eq("mid_regrant", bus_a.mem_req, 1);
      check_eq("mid_addr", bus_a.mem_addr, 32'h600);
      mem_ack = 1'b1; mem_rdata = 32'h66;
      tick;
      check_eq("mid_ack", bus_a.i_ack, 1);
      check_eq("mid_rdata", bus_a.i_rdata, 32'h66);
      mem_ack = 1'b0; i_req = 1'b0;
      tick;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one backing main-memory port between the instruction-fetch refill path and the data-memory access path of the 5-stage pipeline.
- Accepts one request at a time and drives a single request/acknowledge transaction to memory.
- Returns the read data to the owning requester with a one-cycle ack pulse.
- Resolves simultaneous requests by alternating grants and guards against a hung memory with a watchdog timeout.
- Its acks are what release inst_stall / data_stall in the fetch and memory stages.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 64, maximum cycles mem_req is held without mem_ack before the transaction is aborted (must be >= 2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- i_req  in  1  fetch-side read request; held until i_ack.
- i_addr  in  AW  fetch address; stable while i_req is high.
- i_rdata  out  DW  fetch read data; valid in the i_ack cycle.
- i_ack  out  1  one-cycle completion pulse to fetch.
- d_req  in  1  data-side request; held until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  data read data; valid in the d_ack cycle.
- d_ack  out  1  one-cycle completion pulse to the data side.
- mem_req  out  1  request to main memory; held until mem_ack or timeout.
- mem_we  out  1  write strobe qualifier.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- bus_err  out  1  pulses together with i_ack/d_ack when the transaction timed out.
- owner  out  2  00 none, 01 fetch, 10 data; the current bus owner.

Behaviour:
- FSM states: IDLE, BUS, RESP.
- Reset (reset == 0 at a clock edge):
  - State goes to IDLE and the watchdog count to 0.
  - All outputs go to 0, including rdata registers and owner.
  - last_grant is set to FETCH, so the first tie goes to the data side.
  - An in-flight transaction is abandoned: mem_req is low from the first reset cycle and no ack is issued.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the side not equal to last_grant.
  - On grant, latch addr, we (0 for fetch), and wdata into the mem_* registers; set owner and last_grant; go to BUS.
  - mem_req rises in the cycle after the request is first seen.
- BUS:
  - mem_req = 1 and the watchdog increments every cycle.
  - On mem_ack: latch mem_rdata into the owner's rdata register and go to RESP.
  - If the count reaches TIMEOUT - 1 with no mem_ack: drop mem_req, load rdata = 0, set the error flag, go to RESP.
  - A mem_ack arriving in the same cycle as the timeout wins; no error is flagged.
- RESP:
  - Pulse the owner's ack for exactly one cycle; bus_err follows the error flag.
  - mem_req = 0.
  - Clear owner, the error flag and the count; return to IDLE.
  - Requests are not sampled in RESP, so a requester has one cycle to drop its req.
- Latency: req seen at edge N gives mem_req at N+1; mem_ack at N+k (k >= 1) gives ack at N+k+1. Minimum is 2 cycles.
- Writes: d_rdata still captures mem_rdata; the value is don't-care to the consumer.
- Only one transaction is outstanding at a time; no pipelining across requesters.
- The non-owner's ack is never asserted, and the non-owner's rdata register holds its last value.
- Fairness: under continuous dual requests, grants strictly alternate D, I, D, I, ...
- mem_ack while in IDLE or RESP is ignored.

Decomposition:
- Shared package holds:
  - the state encodings (IDLE/BUS/RESP);
  - the owner encodings (NONE/FETCH/DATA);
  - the TIMEOUT default.
- One sub-module, bus_watchdog:
  - ports: clk, reset, run, clear, expired;
  - a counter of width clog2(TIMEOUT) with a terminal-count compare.
  - The arbiter FSM, grant logic and data registers stay in the top module.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; mem_ack one cycle after mem_req with mem_rdata=0x8C220004 -> mem_addr=0x100, mem_we=0, i_ack at cycle 3 with i_rdata=0x8C220004, owner back to 00.
- Simultaneous requests from reset: i_req, d_req both high (d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF) -> data granted first (mem_we=1, mem_wdata=0xDEADBEEF, d_ack), then fetch granted, i_ack; then holding both high gives an alternating D, I, D, I ack sequence.
- Slow memory: mem_ack delayed 10 cycles -> mem_req held 10 cycles with stable mem_addr, single ack pulse, bus_err=0.
- Timeout: TIMEOUT=8, mem_ack never asserted -> mem_req high for exactly 7 cycles, then d_ack=1 with bus_err=1 and d_rdata=0; next request proceeds normally.
- Reset mid-transaction: reset=0 while in BUS -> next edge mem_req=0, owner=00, no ack; after release a new i_req completes normally.
- Boundary: mem_ack coincides with the timeout cycle -> ack with bus_err=0 and data = mem_rdata; a stray mem_ack in IDLE -> no ack, state stays IDLE.
